// File: rtl/burst_decoder_if.sv
// Handshake bundle between the control unit and the burst decoder.
// The control unit drives the request side and the decoder drives the enable and status side.
interface burst_decoder_if #(
  parameter int SEL_WIDTH = 4
);
  localparam int OUT_WIDTH = 2 ** SEL_WIDTH;

  logic                 start;
  logic [SEL_WIDTH-1:0] base;
  logic [SEL_WIDTH:0]   count;
  logic                 hold;
  logic                 abort;
  logic [OUT_WIDTH-1:0] out;
  logic [SEL_WIDTH-1:0] cur_sel;
  logic                 busy;
  logic                 done;

  modport master (
    output start, base, count, hold, abort,
    input  out, cur_sel, busy, done
  );

  modport slave (
    input  start, base, count, hold, abort,
    output out, cur_sel, busy, done
  );
endinterface

// File: rtl/burst_decoder.sv
// Registered one-hot load-enable generator for register-file bursts.
// Starting at a base selector, it issues one enable per cycle for a clamped count, with hold and abort.
//
// state | meaning
// IDLE  | no burst in progress, out=0, waiting for start
// BURST | issuing enables (or stalled by hold), busy=1
// DONE  | single-cycle completion pulse, done=1
module burst_decoder #(
  parameter int SEL_WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  burst_decoder_if.slave bus
);
  localparam int OUT_WIDTH = 2 ** SEL_WIDTH;
  localparam logic [SEL_WIDTH:0]   CNT_MAX = (SEL_WIDTH + 1)'(OUT_WIDTH);
  localparam logic [SEL_WIDTH:0]   CNT_ONE = (SEL_WIDTH + 1)'(1);
  localparam logic [SEL_WIDTH-1:0] SEL_ONE = SEL_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH:0]   rem_q, rem_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [SEL_WIDTH-1:0] cur_sel_q, cur_sel_d;
  logic                 busy_q, done_q;
  logic [SEL_WIDTH:0]   eff;

  function automatic logic [OUT_WIDTH-1:0] onehot(input logic [SEL_WIDTH-1:0] s);
    logic [OUT_WIDTH-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Clamping keeps every register enabled at most once per burst.
  assign eff = (bus.count > CNT_MAX) ? CNT_MAX : bus.count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rem_q     <= '0;
      out_q     <= '0;
      cur_sel_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rem_q     <= rem_d;
      out_q     <= out_d;
      cur_sel_q <= cur_sel_d;
      busy_q    <= (state_d == BURST);
      done_q    <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rem_d     = rem_q;
    out_d     = '0;
    cur_sel_d = cur_sel_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (eff == '0) begin
            state_d = DONE;
          end else begin
            out_d     = onehot(bus.base);
            cur_sel_d = bus.base;
            sel_d     = bus.base + SEL_ONE;
            rem_d     = eff - CNT_ONE;
            state_d   = BURST;
          end
        end
      end
      BURST: begin
        // abort outranks completion, which outranks hold
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else if (!bus.hold) begin
          out_d     = onehot(sel_q);
          cur_sel_d = sel_q;
          sel_d     = sel_q + SEL_ONE;
          rem_d     = rem_q - CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.out     = out_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_burst_decoder.sv
// Self-checking bench for burst_decoder: directed scenarios plus randomized bursts
// compared cycle by cycle against a trace built from the burst rules.
module tb_burst_decoder;
  localparam int SW = 4;
  localparam int OW = 16;

  typedef struct packed {
    logic [OW-1:0] out;
    logic [SW-1:0] sel;
    logic          busy;
    logic          done;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];
  obs_t obs_q[$];

  burst_decoder_if #(.SEL_WIDTH(SW)) bus ();
  burst_decoder #(.SEL_WIDTH(SW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic push_exp(input logic [OW-1:0] o, input int s, input logic b, input logic d);
    obs_t e;
    e.out  = o;
    e.sel  = SW'(s);
    e.busy = b;
    e.done = d;
    exp_q.push_back(e);
  endtask

  // Expected trace from cycle 1 (the cycle after start is sampled) until back in IDLE.
  // hv[i] / ab==i describe hold / abort sampled at the edge that begins cycle i.
  task automatic model_burst(input int b, input int cnt, input logic [63:0] hv, input int ab);
    int eff;
    int k;
    exp_q.delete();
    eff = (cnt > OW) ? OW : cnt;
    if (eff == 0) begin
      push_exp('0, 0, 1'b0, 1'b1);
      push_exp('0, 0, 1'b0, 1'b0);
      return;
    end
    push_exp(OW'(1) << b, b, 1'b1, 1'b0);
    k = 1;
    for (int i = 2; i < 64; i++) begin
      if (ab == i) begin
        push_exp('0, 0, 1'b0, 1'b0);
        push_exp('0, 0, 1'b0, 1'b0);
        return;
      end
      if (k == eff) begin
        push_exp('0, 0, 1'b0, 1'b1);
        push_exp('0, 0, 1'b0, 1'b0);
        return;
      end
      if (hv[i]) begin
        push_exp('0, 0, 1'b1, 1'b0);
      end else begin
        push_exp(OW'(1) << ((b + k) % OW), (b + k) % OW, 1'b1, 1'b0);
        k++;
      end
    end
  endtask

  // Drives one burst and records outputs for as many cycles as the expected trace holds.
  // noise injects start pulses only while the burst is in BURST or DONE.
  task automatic drive_burst(input int b, input int cnt, input logic [63:0] hv, input int ab,
                             input bit noise);
    obs_t o;
    obs_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.base  = SW'(b);
    bus.count = 5'(cnt);
    bus.hold  = 1'($urandom);
    bus.abort = 1'($urandom);
    @(posedge clk);
    for (int i = 1; i <= exp_q.size(); i++) begin
      @(negedge clk);
      o.out  = bus.out;
      o.sel  = bus.cur_sel;
      o.busy = bus.busy;
      o.done = bus.done;
      obs_q.push_back(o);
      bus.hold  = (i + 1 < 64) ? hv[i+1] : 1'b0;
      bus.abort = (ab == i + 1);
      bus.start = (noise && (exp_q[i-1].busy || exp_q[i-1].done)) ? 1'($urandom) : 1'b0;
      bus.base  = SW'($urandom);
      bus.count = 5'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.base = '0; bus.count = '0; bus.hold = 1'b0; bus.abort = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL reset_out: got %h want 0", bus.out); end
    checks++; if (bus.cur_sel !== '0) begin errors++; $display("FAIL reset_sel: got %0d want 0", bus.cur_sel); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    int   bs[5]  = '{3, 14, 0, 0, 5};
    int   cs[5]  = '{4, 4, 3, 0, 8};
    logic [63:0] hs[5] = '{64'h0, 64'h0, 64'hC, 64'h0, 64'h0};
    int   as[5]  = '{0, 0, 0, 0, 4};
    bit   ns[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    string nm[5] = '{"basic", "wrap", "hold", "count0", "abort"};
    for (int t = 0; t < 5; t++) begin
      model_burst(bs[t], cs[t], hs[t], as[t]);
      drive_burst(bs[t], cs[t], hs[t], as[t], ns[t]);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].out !== exp_q[i].out || obs_q[i].busy !== exp_q[i].busy ||
            obs_q[i].done !== exp_q[i].done ||
            (exp_q[i].out != '0 && obs_q[i].sel !== exp_q[i].sel)) begin
          errors++;
          $display("FAIL %s cyc %0d: got out=%h sel=%0d busy=%b done=%b, want out=%h sel=%0d busy=%b done=%b",
                   nm[t], i + 1, obs_q[i].out, obs_q[i].sel, obs_q[i].busy, obs_q[i].done,
                   exp_q[i].out, exp_q[i].sel, exp_q[i].busy, exp_q[i].done);
        end
      end
    end
  endtask

  task automatic test_boundaries;
    int bs[3] = '{7, 0, 9};
    int cs[3] = '{20, 1, 16};
    logic [OW-1:0] seen;
    for (int t = 0; t < 3; t++) begin
      model_burst(bs[t], cs[t], 64'h0, 0);
      drive_burst(bs[t], cs[t], 64'h0, 0, 1'b1);
      seen = '0;
      for (int i = 0; i < exp_q.size(); i++) begin
        seen |= obs_q[i].out;
        checks++;
        if (obs_q[i].out !== exp_q[i].out || obs_q[i].busy !== exp_q[i].busy ||
            obs_q[i].done !== exp_q[i].done ||
            (exp_q[i].out != '0 && obs_q[i].sel !== exp_q[i].sel)) begin
          errors++;
          $display("FAIL bound count=%0d cyc %0d: got out=%h sel=%0d busy=%b done=%b, want out=%h sel=%0d busy=%b done=%b",
                   cs[t], i + 1, obs_q[i].out, obs_q[i].sel, obs_q[i].busy, obs_q[i].done,
                   exp_q[i].out, exp_q[i].sel, exp_q[i].busy, exp_q[i].done);
        end
      end
      if (cs[t] >= OW) begin
        checks++;
        if (seen !== 16'hFFFF) begin
          errors++; $display("FAIL bound_cover count=%0d: got %h want ffff", cs[t], seen);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    @(negedge clk);
    bus.start = 1'b1; bus.base = SW'(5); bus.count = 5'd8;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_pre_busy: got %b want 1", bus.busy); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.out !== '0) begin errors++; $display("FAIL midrst_out: got %h want 0", bus.out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    @(negedge clk);
    reset_n = 1'b1;
    model_burst(0, 2, 64'h0, 0);
    drive_burst(0, 2, 64'h0, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].out !== exp_q[i].out || obs_q[i].busy !== exp_q[i].busy ||
          obs_q[i].done !== exp_q[i].done ||
          (exp_q[i].out != '0 && obs_q[i].sel !== exp_q[i].sel)) begin
        errors++;
        $display("FAIL after_rst cyc %0d: got out=%h busy=%b done=%b, want out=%h busy=%b done=%b",
                 i + 1, obs_q[i].out, obs_q[i].busy, obs_q[i].done,
                 exp_q[i].out, exp_q[i].busy, exp_q[i].done);
      end
    end
  endtask

  task automatic test_random;
    int b, c, ab;
    logic [63:0] hv;
    for (int t = 0; t < 40; t++) begin
      b  = $urandom_range(0, OW - 1);
      c  = $urandom_range(0, 31);
      hv = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_01FF_FFFF_FFFC;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 20) : 0;
      model_burst(b, c, hv, ab);
      drive_burst(b, c, hv, ab, 1'b1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i].out !== exp_q[i].out || obs_q[i].busy !== exp_q[i].busy ||
            obs_q[i].done !== exp_q[i].done ||
            (exp_q[i].out != '0 && obs_q[i].sel !== exp_q[i].sel)) begin
          errors++;
          $display("FAIL rand#%0d base=%0d cnt=%0d cyc %0d: got out=%h sel=%0d busy=%b done=%b, want out=%h sel=%0d busy=%b done=%b",
                   t, b, c, i + 1, obs_q[i].out, obs_q[i].sel, obs_q[i].busy, obs_q[i].done,
                   exp_q[i].out, exp_q[i].sel, exp_q[i].busy, exp_q[i].done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
